prog_loader: RTL and testbench
==============================

# prog_loader

Loads a program and its initial data into the CPU's instruction and data memories from a 32-bit valid/ready word stream, then releases the CPU from reset. Sits between an external host or boot ROM streamer and `CPU`. It is the writer-side counterpart to the state dump taken at the end of simulation: it establishes instruction memory, data memory and the start condition that the dump later reads back. It owns the CPU's active-low reset (`rst_n`) and drives the instruction-memory and data-memory write ports while the CPU is held.

## Interface
- `IMEM_DEPTH`, 256, instruction memory depth in 32-bit words
- `DMEM_DEPTH`, 32, data memory depth in 32-bit words
- `ADDR_W`, 8, word-address width; must satisfy 2^ADDR_W >= max(IMEM_DEPTH, DMEM_DEPTH)

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `in_valid_i`  in  1  stream word valid
- `in_data_i`  in  32  stream word
- `in_ready_o`  out  1  loader accepts a word this cycle
- `imem_we_o`  out  1  instruction memory write strobe
- `dmem_we_o`  out  1  data memory write strobe
- `mem_addr_o`  out  ADDR_W  word address, shared by both strobes
- `mem_wdata_o`  out  32  write data, shared by both strobes
- `cpu_rst_n_o`  out  1  drives CPU `rst_n`; 0 holds the CPU in reset
- `done_o`  out  1  CPU has been released
- `err_o`  out  1  sticky error flag

## Operation
- A word is accepted on a rising edge where `in_valid_i && in_ready_o` is true. Each word is accepted exactly once.
- Header word fields:
  - [31:30] cmd: 00 = load IMEM, 01 = load DMEM, 10 = START, 11 = illegal.
  - [23:16] start word address.
  - [15:0] count N of data words that follow.
- FSM states: HDR, DATA, RUN.
- HDR:
  - cmd 00 or 01 with N>0: latch target, address and count; go to DATA.
  - cmd 00 or 01 with N=0: no-op; stay in HDR.
  - cmd 10: go to RUN.
  - cmd 11: set `err_o`; stay in HDR. The word is consumed.
- DATA:
  - Each accepted word issues one write to the latched target at the current address.
  - After each write, address increments and count decrements.
  - After the N-th word, return to HDR.
- Bounds: if the write address is >= the depth of the target memory, suppress the strobe and set `err_o`. The word is still consumed so stream alignment is kept.
  - The address counter is ADDR_W+1 bits internally, so it never wraps into valid space.
- RUN: `in_ready_o`=0 and input is ignored. `cpu_rst_n_o`=1 and `done_o`=1. Only `rst_i` leaves RUN.
- `err_o` is sticky until `rst_i`. An error never blocks START.
- `imem_we_o` and `dmem_we_o` are never high together.

## Timing
- Reset values, in effect asynchronously while `rst_i`=1:
  - State is HDR.
  - `in_ready_o`, `imem_we_o`, `dmem_we_o`, `cpu_rst_n_o`, `done_o` and `err_o` are all 0.
  - `mem_addr_o` and `mem_wdata_o` are 0.
- `in_ready_o` is registered. It goes to 1 on the first rising edge after `rst_i` falls, and stays 1 in HDR and DATA.
- Write latency: a data word accepted at edge k produces its strobe, `mem_addr_o` and `mem_wdata_o` during the cycle after edge k, high for exactly one cycle. Memories capture it at edge k+1.
- Throughput: one word per cycle with no bubbles, including HDR→DATA→HDR back-to-back and a final data word followed directly by the next header.
- START accepted at edge k:
  - `cpu_rst_n_o` and `done_o` rise after edge k.
  - The last memory write, accepted at k-1 at the latest, completes at edge k, before the CPU leaves reset.
- `in_valid_i` low stalls the FSM with no state change. Strobes are 0 in any cycle with no pending write.
- `rst_i` asserted mid-DATA or in RUN:
  - Outputs return to reset values immediately, and `cpu_rst_n_o`=0 asynchronously.
  - Partial loads are abandoned.
  - Memory contents are not cleared.

## Test plan
- IMEM load: header 0x0000_0003 plus words A, B, C, then START → `imem_we_o` at addresses 0, 1, 2 with A, B, C on consecutive cycles; `cpu_rst_n_o`=1 the cycle after START; `err_o`=0.
- DMEM load: header 0x4000_0005 plus 5, 6, 10, 18, 29 with `in_valid_i` toggling every other cycle → `dmem_we_o` at addresses 0 to 4 only on accept+1 cycles; memory ends as [5, 6, 10, 18, 29].
- Overflow: DMEM header with start 30, N=4 → writes at 30 and 31 only; `err_o` rises on the third word; the next header is parsed correctly.
- Illegal and no-op headers: 0xC000_0000 then 0x0000_0000 then START → `err_o`=1, no strobes, `done_o`=1 after START, `in_ready_o`=0 afterward.
- Reset mid-load: assert `rst_i` after 2 of 4 IMEM words → all outputs 0 immediately; after release, `in_ready_o`=1 one edge later and a fresh load is parsed from HDR.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot-time program/data loader driving the CPU memories and reset.
// Latency: a data word accepted at edge k is presented on the memory write port
// during the following cycle. Backpressure: in_ready_o drops only once START is taken.
//
// Ports:
//   clk_i, rst_i               clock and asynchronous active-high reset
//   in_valid_i/in_data_i       32-bit command/data word stream
//   in_ready_o                 registered ready; high in HDR and DATA
//   imem_we_o, dmem_we_o       one-cycle write strobes (mutually exclusive)
//   mem_addr_o, mem_wdata_o    shared word address and write data
//   cpu_rst_n_o, done_o        CPU released (both high only in RUN)
//   err_o                      sticky error: illegal command or out-of-range write
module prog_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 32,
  parameter int ADDR_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [31:0]       in_data_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_HDR  = 2'b00,
    S_DATA = 2'b01,
    S_RUN  = 2'b10
  } state_e;

  // Header command encodings (bits [31:30]).
  localparam logic [1:0] CMD_IMEM  = 2'b00;
  localparam logic [1:0] CMD_DMEM  = 2'b01;
  localparam logic [1:0] CMD_START = 2'b10;

  // Memory limits in the widened address domain, so a depth equal to
  // 2^ADDR_W is still representable.
  localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W + 1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] DMEM_LIM = (ADDR_W + 1)'(DMEM_DEPTH);
  localparam logic [ADDR_W:0] CUR_MAX  = '1;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              imem_we_q, imem_we_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  // Running write address, one bit wider than the port so that running off
  // the end of a memory lands in invalid space instead of wrapping to 0.
  logic [ADDR_W:0]   cur_q, cur_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              tgt_q, tgt_d;   // 0: IMEM, 1: DMEM

  logic              accept;
  logic [1:0]        hdr_cmd;
  logic [15:0]       hdr_cnt;
  logic [ADDR_W:0]   hdr_addr;
  logic [ADDR_W:0]   cur_lim;
  logic              in_bounds;
  logic              unused_hdr_bits;

  assign accept    = in_valid_i & ready_q;
  assign hdr_cmd   = in_data_i[31:30];
  assign hdr_cnt   = in_data_i[15:0];
  assign hdr_addr  = (ADDR_W + 1)'(in_data_i[23:16]);
  assign cur_lim   = tgt_q ? DMEM_LIM : IMEM_LIM;
  assign in_bounds = (cur_q < cur_lim);

  // Header bits [29:24] are reserved and carry no meaning.
  assign unused_hdr_bits = ^in_data_i[29:24];

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_HDR;
      ready_q   <= 1'b0;
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      cur_q     <= '0;
      cnt_q     <= '0;
      tgt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      imem_we_q <= imem_we_d;
      dmem_we_q <= dmem_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    imem_we_d = 1'b0;     // strobes last exactly one cycle
    dmem_we_d = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          case (hdr_cmd)
            CMD_IMEM, CMD_DMEM: begin
              // A zero-length load is a legal no-op.
              if (hdr_cnt != 16'd0) begin
                tgt_d   = (hdr_cmd == CMD_DMEM);
                cur_d   = hdr_addr;
                cnt_d   = hdr_cnt;
                state_d = S_DATA;
              end
            end
            CMD_START: begin
              state_d = S_RUN;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      S_DATA: begin
        if (accept) begin
          if (in_bounds) begin
            imem_we_d = ~tgt_q;
            dmem_we_d = tgt_q;
            addr_d    = cur_q[ADDR_W-1:0];
            wdata_d   = in_data_i;
          end else begin
            // Word is still consumed so the stream stays aligned.
            err_d = 1'b1;
          end
          // Saturate so a very long burst can never wrap back into range.
          if (cur_q != CUR_MAX) begin
            cur_d = cur_q + 1'b1;
          end
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_HDR;
          end
        end
      end

      S_RUN: begin
        // Terminal until rst_i; the stream is ignored.
      end

      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  // Ready follows the next state so it is already low in the first RUN cycle.
  assign ready_d = (state_d != S_RUN);

  assign in_ready_o  = ready_q;
  assign imem_we_o   = imem_we_q;
  assign dmem_we_o   = dmem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;
  // Derived directly from the state register so rst_i clears them at once.
  assign cpu_rst_n_o = (state_q == S_RUN);
  assign done_o      = (state_q == S_RUN);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = 32'h0;
  logic        in_ready_o;
  logic        imem_we_o;
  logic        dmem_we_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        cpu_rst_n_o;
  logic        done_o;
  logic        err_o;

  prog_loader #(.IMEM_DEPTH(256), .DMEM_DEPTH(32), .ADDR_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .imem_we_o   (imem_we_o),
    .dmem_we_o   (dmem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .cpu_rst_n_o (cpu_rst_n_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        dm;
    logic        im;
    logic [7:0]  addr;
    logic [31:0] dat;
    logic [31:0] cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [31:0] cyc = 32'd0;
  logic [31:0] tb_dmem [0:31];
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk_i) cyc <= cyc + 32'd1;

  // Monitor: capture every write strobe with the cycle it appeared in.
  always @(negedge clk_i) begin
    if (imem_we_o || dmem_we_o) begin
      obs_q.push_back('{dm: dmem_we_o, im: imem_we_o, addr: mem_addr_o,
                        dat: mem_wdata_o, cyc: cyc});
      if (dmem_we_o && mem_addr_o < 8'd32) tb_dmem[mem_addr_o[4:0]] = mem_wdata_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic dm, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] c);
    exp_q.push_back('{dm: dm, im: ~dm, addr: a, dat: d, cyc: c});
  endtask

  // Compare observed writes against the scoreboard, then drain both queues.
  task automatic check_writes(input string tag);
    wr_t e, o;
    int  n;
    tests++;
    assert (obs_q.size() === exp_q.size()) else begin
      fails++;
      $error("FAIL %s count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      assert (o === e) else begin
        fails++;
        $error("FAIL %s write%0d: got dm=%b im=%b a=%h d=%h cyc=%0d expected dm=%b im=%b a=%h d=%h cyc=%0d",
               tag, i, o.dm, o.im, o.addr, o.dat, o.cyc, e.dm, e.im, e.addr, e.dat, e.cyc);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // Present a word from a falling edge and hold it until accepted. Returns at
  // the falling edge after acceptance, with c = cycle in which the strobe shows.
  task automatic send(input logic [31:0] w, output logic [31:0] c);
    int n;
    in_valid_i = 1'b1;
    in_data_i  = w;
    n = 0;
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    c = 32'd0;
    if (n >= 50) begin
      chk("send_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clk_i);
      @(negedge clk_i);
      c = cyc;
    end
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready_o}, 32'd0);
    chk({tag, "_we"},    {30'd0, imem_we_o, dmem_we_o}, 32'd0);
    chk({tag, "_addr"},  {24'd0, mem_addr_o}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_rstn"},  {31'd0, cpu_rst_n_o}, 32'd0);
    chk({tag, "_done"},  {31'd0, done_o}, 32'd0);
    chk({tag, "_err"},   {31'd0, err_o}, 32'd0);
  endtask

  task automatic do_reset();
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    obs_q.delete();
    exp_q.delete();
  endtask

  logic [31:0] c0, c1, c2, c3, c4;
  logic [31:0] dvals [5];

  initial begin
    for (int i = 0; i < 32; i++) tb_dmem[i] = 32'hDEAD_0000;
    dvals[0] = 32'd5; dvals[1] = 32'd6; dvals[2] = 32'd10; dvals[3] = 32'd18; dvals[4] = 32'd29;

    // ---- Reset values and ready timing ----
    @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    #1 chk("ready_before_edge", {31'd0, in_ready_o}, 32'd0);
    @(negedge clk_i);
    chk("ready_after_edge", {31'd0, in_ready_o}, 32'd1);

    // ---- IMEM load, back-to-back, then START ----
    send(32'h0000_0003, c0);
    send(32'hAAAA_0001, c1); exp_wr(1'b0, 8'd0, 32'hAAAA_0001, c1);
    send(32'hBBBB_0002, c2); exp_wr(1'b0, 8'd1, 32'hBBBB_0002, c2);
    send(32'hCCCC_0003, c3); exp_wr(1'b0, 8'd2, 32'hCCCC_0003, c3);
    send(32'h8000_0000, c4);
    chk("imem_no_bubbles", c4 - c0, 32'd4);
    chk("start_rstn", {31'd0, cpu_rst_n_o}, 32'd1);
    chk("start_done", {31'd0, done_o}, 32'd1);
    chk("start_ready", {31'd0, in_ready_o}, 32'd0);
    chk("imem_err", {31'd0, err_o}, 32'd0);
    check_writes("imem");
    // RUN ignores the stream even with valid held high.
    in_data_i = 32'h0000_0001;
    repeat (4) @(negedge clk_i);
    chk("run_ready", {31'd0, in_ready_o}, 32'd0);
    chk("run_done", {31'd0, done_o}, 32'd1);
    idle(1);
    check_writes("run_ignore");

    // ---- DMEM load with valid toggling ----
    do_reset();
    send(32'h4000_0005, c0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      send(dvals[i], c1);
      exp_wr(1'b1, 8'(i), dvals[i], c1);
    end
    idle(2);
    check_writes("dmem");
    for (int i = 0; i < 5; i++) chk($sformatf("dmem_mem%0d", i), tb_dmem[i], dvals[i]);
    chk("dmem_err", {31'd0, err_o}, 32'd0);

    // ---- Overflow past DMEM end, then the next header ----
    send(32'h401E_0004, c0);
    send(32'h0000_0130, c1); exp_wr(1'b1, 8'd30, 32'h0000_0130, c1);
    send(32'h0000_0131, c2); exp_wr(1'b1, 8'd31, 32'h0000_0131, c2);
    chk("ovf_err_pre", {31'd0, err_o}, 32'd0);
    send(32'h0000_0132, c3);
    chk("ovf_err_third", {31'd0, err_o}, 32'd1);
    send(32'h0000_0133, c3);
    send(32'h0005_0001, c4);
    send(32'h0000_0055, c4); exp_wr(1'b0, 8'd5, 32'h0000_0055, c4);
    idle(2);
    check_writes("overflow");
    chk("ovf_err_sticky", {31'd0, err_o}, 32'd1);

    // ---- Illegal and no-op headers, then START ----
    do_reset();
    send(32'hC000_0000, c0);
    chk("illegal_err", {31'd0, err_o}, 32'd1);
    send(32'h0000_0000, c1);
    send(32'h8000_0000, c2);
    idle(2);
    check_writes("illegal_nostrobe");
    chk("illegal_done", {31'd0, done_o}, 32'd1);
    chk("illegal_ready", {31'd0, in_ready_o}, 32'd0);

    // ---- Reset in the middle of an IMEM load ----
    do_reset();
    send(32'h0010_0004, c0);
    send(32'h1111_0000, c1); exp_wr(1'b0, 8'h10, 32'h1111_0000, c1);
    send(32'h2222_0000, c2); exp_wr(1'b0, 8'h11, 32'h2222_0000, c2);
    #2 rst_i = 1'b1;
    #1 check_reset_outputs("midrst");
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check_writes("midrst_partial");
    rst_i = 1'b0;
    #1 chk("midrst_ready_low", {31'd0, in_ready_o}, 32'd0);
    @(negedge clk_i);
    chk("midrst_ready_high", {31'd0, in_ready_o}, 32'd1);
    send(32'h0020_0001, c0);
    send(32'h3333_0000, c1); exp_wr(1'b0, 8'h20, 32'h3333_0000, c1);
    send(32'h8000_0000, c2);
    idle(1);
    check_writes("midrst_fresh");
    chk("midrst_done", {31'd0, done_o}, 32'd1);
    chk("midrst_err", {31'd0, err_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
